// File: rtl/bf_instr_fetch.sv
// TinyBF instruction fetch stage.
// Drives the program memory read port from a program counter, registers the
// returned word, splits it into opcode/argument and offers it to the execute
// stage over valid/ready. Handles branch redirects, HALT (all-zero word) and
// the start-up window while program memory initialises itself.
module bf_instr_fetch #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int INIT_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   output logic              mem_ren_o,
   output logic [ADDR_W-1:0] mem_raddr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [2:0]        instr_opcode_o,
   output logic [DATA_W-4:0] instr_arg_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              halted_o,
   output logic              ready_o
);

   // Init counter sized to hold 0 .. INIT_CYCLES-1.
   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);
   // ready_o is a register; load it one count early so it is already high
   // during the final counting cycle.
   localparam logic [CNT_W-1:0] CNT_RDY  = (INIT_CYCLES >= 2) ? CNT_W'(INIT_CYCLES - 2) : '0;

   typedef enum logic [2:0] {
      S_WAIT_INIT = 3'd0,
      S_IDLE      = 3'd1,
      S_FETCH     = 3'd2,
      S_RESP      = 3'd3,
      S_VALID     = 3'd4,
      S_HALTED    = 3'd5
   } t_state;

   t_state              r_state;
   t_state              w_state_next;
   logic [CNT_W-1:0]    r_init_cnt;
   logic                r_start_pend;
   logic [ADDR_W-1:0]   r_pc;
   logic                r_instr_valid;
   logic [2:0]          r_instr_opcode;
   logic [DATA_W-4:0]   r_instr_arg;
   logic [ADDR_W-1:0]   r_instr_pc;
   logic                r_halted;
   logic                r_ready;

   logic                w_init_done;
   logic                w_abort;
   logic                w_handshake;
   logic                w_rdata_halt;
   logic                w_start_go;
   logic [ADDR_W-1:0]   w_pc_inc;

   // Stop applies everywhere except the init window, where it only cancels a
   // pending start.
   assign w_init_done  = (r_state == S_WAIT_INIT) && (r_init_cnt == CNT_LAST);
   assign w_abort      = stop_i && (r_state != S_WAIT_INIT);
   assign w_handshake  = (r_state == S_VALID) && r_instr_valid && instr_ready_i;
   assign w_rdata_halt = (mem_rdata_i == '0);
   assign w_pc_inc     = r_pc + ADDR_W'(1);
   // A start seen during init (or on its last cycle) launches at PC 0.
   assign w_start_go   = (r_start_pend || start_i) && !stop_i;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_WAIT_INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; stop overrides every other transition outside init.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_WAIT_INIT: begin
            if (w_init_done) begin
               w_state_next = w_start_go ? S_FETCH : S_IDLE;
            end
         end
         S_IDLE: begin
            if (start_i) begin
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            w_state_next = S_RESP;
         end
         S_RESP: begin
            w_state_next = w_rdata_halt ? S_HALTED : S_VALID;
         end
         S_VALID: begin
            if (w_handshake) begin
               w_state_next = S_FETCH;
            end
         end
         S_HALTED: begin
            if (start_i) begin
               w_state_next = S_FETCH;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (w_abort) begin
         w_state_next = S_IDLE;
      end
   end

   // Memory read port: exactly one read per FETCH cycle, address is the PC.
   always_comb begin
      mem_ren_o   = (r_state == S_FETCH);
      mem_raddr_o = r_pc;
   end

   // Post-reset init counter; freezes once the window has elapsed.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_init_cnt <= '0;
      end else if ((r_state == S_WAIT_INIT) && !w_init_done) begin
         r_init_cnt <= r_init_cnt + CNT_W'(1);
      end
   end

   // Remember a start request that arrives before memory is ready.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_start_pend <= 1'b0;
      end else if (r_state == S_WAIT_INIT) begin
         if (stop_i || w_init_done) begin
            r_start_pend <= 1'b0;
         end else if (start_i) begin
            r_start_pend <= 1'b1;
         end
      end
   end

   // ready_o rises at the end of the init window and stays up until reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ready <= 1'b0;
      end else if ((r_state == S_WAIT_INIT) && ((r_init_cnt == CNT_RDY) || w_init_done)) begin
         r_ready <= 1'b1;
      end
   end

   // Program counter: restart at 0 on start, advance or redirect on handshake.
   // An aborted handshake leaves the PC untouched.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_pc <= '0;
      end else if (!w_abort) begin
         case (r_state)
            S_WAIT_INIT: begin
               if (w_init_done) begin
                  r_pc <= '0;
               end
            end
            S_IDLE, S_HALTED: begin
               if (start_i) begin
                  r_pc <= '0;
               end
            end
            S_VALID: begin
               if (w_handshake) begin
                  r_pc <= redirect_i ? redirect_pc_i : w_pc_inc;
               end
            end
            default: begin
               r_pc <= r_pc;
            end
         endcase
      end
   end

   // Capture the returned word, detect HALT, and run the valid/ready flag.
   // Instruction fields hold their last value after the handshake.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_instr_valid  <= 1'b0;
         r_instr_opcode <= '0;
         r_instr_arg    <= '0;
         r_instr_pc     <= '0;
         r_halted       <= 1'b0;
      end else if (w_abort) begin
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         case (r_state)
            S_RESP: begin
               if (w_rdata_halt) begin
                  r_halted <= 1'b1;
               end else begin
                  r_instr_valid  <= 1'b1;
                  r_instr_opcode <= mem_rdata_i[DATA_W-1:DATA_W-3];
                  r_instr_arg    <= mem_rdata_i[DATA_W-4:0];
                  r_instr_pc     <= r_pc;
               end
            end
            S_VALID: begin
               if (w_handshake) begin
                  r_instr_valid <= 1'b0;
               end
            end
            S_HALTED: begin
               if (start_i) begin
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_instr_valid <= r_instr_valid;
            end
         endcase
      end
   end

   // Registered outputs.
   always_comb begin
      instr_valid_o  = r_instr_valid;
      instr_opcode_o = r_instr_opcode;
      instr_arg_o    = r_instr_arg;
      instr_pc_o     = r_instr_pc;
      halted_o       = r_halted;
      ready_o        = r_ready;
   end

endmodule

// File: tb/tb_bf_instr_fetch.sv
// Directed testbench for bf_instr_fetch with a small registered-read program
// memory model. Inputs change and outputs are sampled on the falling edge.
module tb_bf_instr_fetch;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic       stop_i;
   logic       mem_ren_o;
   logic [3:0] mem_raddr_o;
   logic [7:0] mem_rdata_i;
   logic       instr_valid_o;
   logic       instr_ready_i;
   logic [2:0] instr_opcode_o;
   logic [4:0] instr_arg_o;
   logic [3:0] instr_pc_o;
   logic       redirect_i;
   logic [3:0] redirect_pc_i;
   logic       halted_o;
   logic       ready_o;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] prog_mem [16];

   always #5 clk_i = ~clk_i;

   bf_instr_fetch #(.ADDR_W(4), .DATA_W(8), .INIT_CYCLES(16)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .stop_i         (stop_i),
      .mem_ren_o      (mem_ren_o),
      .mem_raddr_o    (mem_raddr_o),
      .mem_rdata_i    (mem_rdata_i),
      .instr_valid_o  (instr_valid_o),
      .instr_ready_i  (instr_ready_i),
      .instr_opcode_o (instr_opcode_o),
      .instr_arg_o    (instr_arg_o),
      .instr_pc_o     (instr_pc_o),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .halted_o       (halted_o),
      .ready_o        (ready_o)
   );

   // Program memory: data appears the cycle after the read enable.
   always @(posedge clk_i) begin
      if (mem_ren_o) mem_rdata_i <= prog_mem[mem_raddr_o];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0h", tag, got);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   // Checks the presented instruction: {valid, opcode, arg, pc}.
   task automatic check_instr(input string tag, input logic [2:0] op, input logic [4:0] arg,
                              input logic [3:0] pc);
      check(tag, {28'd0, instr_valid_o, instr_opcode_o, instr_arg_o, instr_pc_o} >> 0,
            {28'd0, 1'b1, op, arg, pc} >> 0);
   endtask

   task automatic check_read(input string tag, input logic [3:0] addr);
      check(tag, {27'd0, mem_ren_o, mem_raddr_o}, {27'd0, 1'b1, addr});
   endtask

   int ren_early;
   logic [12:0] held;

   initial begin
      for (int i = 0; i < 16; i++) prog_mem[i] = 8'h11;
      prog_mem[0]  = 8'h45;  // op 2, arg 5
      prog_mem[1]  = 8'h23;  // op 1, arg 3
      prog_mem[2]  = 8'hA7;  // op 5, arg 7
      prog_mem[3]  = 8'h00;  // HALT
      prog_mem[4]  = 8'h61;  // op 3, arg 1
      prog_mem[10] = 8'h9C;  // op 4, arg 28
      prog_mem[12] = 8'h3F;  // op 1, arg 31
      prog_mem[15] = 8'hE2;  // op 7, arg 2

      rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; instr_ready_i = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = 4'd0;
      repeat (3) step();
      check("reset_outputs", {22'd0, mem_ren_o, mem_raddr_o, instr_valid_o, halted_o, ready_o},
            32'd0);

      // Init window: release reset, pulse start at cycle 3.
      ren_early = 0;
      rst_i = 1'b1;
      instr_ready_i = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) step();
         if (c <= 15 && mem_ren_o) ren_early++;
         if (c == 14) check("ready_c14", {31'd0, ready_o}, 32'd0);
         if (c == 15) check("ready_c15", {31'd0, ready_o}, 32'd1);
         if (c == 16) check_read("first_read_c16", 4'd0);
         start_i = (c == 3);
      end
      check("no_read_c0_15", ren_early, 0);

      // Decode and handshake with ready held high.
      step();  // 17: RESP
      check("valid_latency_low", {31'd0, instr_valid_o}, 32'd0);
      step();  // 18
      check_instr("decode_w0", 3'd2, 5'd5, 4'd0);
      step();  // 19
      check_read("read_addr1", 4'd1);
      instr_ready_i = 1'b0;

      // Backpressure for 5 cycles on word 1.
      step(); step();  // 21
      held = {instr_valid_o, instr_opcode_o, instr_arg_o, instr_pc_o};
      check_instr("decode_w1", 3'd1, 5'd3, 4'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         check($sformatf("hold_%0d", i),
               {18'd0, mem_ren_o, instr_valid_o, instr_opcode_o, instr_arg_o, instr_pc_o},
               {18'd0, 1'b0, held});
      end
      instr_ready_i = 1'b1;
      step();  // 26
      check_read("read_addr2", 4'd2);
      step(); step();  // 28
      check_instr("decode_w2", 3'd5, 5'd7, 4'd2);
      step();  // 29
      check_read("read_addr3", 4'd3);

      // HALT on word 3.
      step();  // 30
      check("halt_not_yet", {31'd0, halted_o}, 32'd0);
      step();  // 31
      check("halted_set", {30'd0, halted_o, instr_valid_o}, 32'b10);
      step();  // 32
      check("halted_idle", {29'd0, halted_o, instr_valid_o, mem_ren_o}, 32'b100);
      start_i = 1'b1;
      step();  // 33
      start_i = 1'b0;
      check("halt_cleared", {31'd0, halted_o}, 32'd0);
      check_read("restart_addr0", 4'd0);

      // Redirect 0 -> 10.
      step(); step();  // 35
      check_instr("decode_w0_again", 3'd2, 5'd5, 4'd0);
      redirect_i = 1'b1; redirect_pc_i = 4'd10;
      step();  // 36
      redirect_i = 1'b0; instr_ready_i = 1'b0;
      check_read("redirect_addr10", 4'd10);
      step(); step();  // 38
      check_instr("decode_w10", 3'd4, 5'd28, 4'd10);
      redirect_i = 1'b1; redirect_pc_i = 4'd7;  // no handshake: ignored
      step();  // 39
      check("redirect_no_hs", {26'd0, instr_valid_o, mem_ren_o, mem_raddr_o}, {26'd0, 2'b10, 4'd10});
      instr_ready_i = 1'b1; redirect_pc_i = 4'd4;
      step();  // 40
      redirect_i = 1'b0;
      check_read("redirect_addr4", 4'd4);
      step(); step();  // 42
      check_instr("decode_w4", 3'd3, 5'd1, 4'd4);
      redirect_i = 1'b1; redirect_pc_i = 4'd15;
      step();  // 43
      redirect_i = 1'b0;
      check_read("redirect_addr15", 4'd15);
      step(); step();  // 45
      check_instr("decode_w15", 3'd7, 5'd2, 4'd15);
      step();  // 46
      check_read("wrap_addr0", 4'd0);

      // Stop during VALID with ready high: discard, no PC advance.
      step(); step();  // 48
      redirect_i = 1'b1; redirect_pc_i = 4'd12;
      step();  // 49
      redirect_i = 1'b0;
      check_read("redirect_addr12", 4'd12);
      step(); step();  // 51
      check_instr("decode_w12", 3'd1, 5'd31, 4'd12);
      stop_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 4'd5;
      step();  // 52
      stop_i = 1'b0; redirect_i = 1'b0;
      check("stop_discard", {26'd0, instr_valid_o, mem_ren_o, mem_raddr_o}, {26'd0, 2'b00, 4'd12});
      step();  // 53
      check("stop_idle", {30'd0, instr_valid_o, mem_ren_o}, 32'd0);
      start_i = 1'b1;
      step();  // 54
      start_i = 1'b0;
      check_read("idle_start_addr0", 4'd0);

      // Async reset during RESP.
      step();  // 55
      #2 rst_i = 1'b0;
      #1;
      check("async_rst_ctl", {27'd0, mem_ren_o, instr_valid_o, halted_o, ready_o, 1'b0}, 32'd0);
      check("async_rst_data", {16'd0, mem_raddr_o, instr_opcode_o, instr_arg_o, instr_pc_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bf_instr_fetch.md
Name: bf_instr_fetch

Overview:
- Instruction fetch stage directly downstream of the TinyBF program memory.
- Sequences the memory read port from a program counter, registers each returned instruction, splits it into a 3-bit opcode and 5-bit argument, and presents it to the execute stage over a valid/ready handshake.
- Handles taken-branch redirects, HALT detection (8'h00), and the post-reset window while program memory is self-initialising.

Parameters:
- ADDR_W, 4, program counter / memory address width (DEPTH = 2**ADDR_W).
- DATA_W, 8, instruction width; opcode = [DATA_W-1:DATA_W-3], arg = [DATA_W-4:0].
- INIT_CYCLES, 16, cycles after reset release before the first read may issue (covers memory init).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  single-cycle pulse: begin execution at PC 0.
- stop_i  in  1  abort fetch, return to IDLE.
- mem_ren_o  out  1  program memory read enable.
- mem_raddr_o  out  ADDR_W  program memory read address.
- mem_rdata_i  in  DATA_W  program memory read data; valid 1 cycle after mem_ren_o.
- instr_valid_o  out  1  decoded instruction available.
- instr_ready_i  in  1  execute stage accepts the instruction.
- instr_opcode_o  out  3  opcode field.
- instr_arg_o  out  DATA_W-3  argument field.
- instr_pc_o  out  ADDR_W  address of the presented instruction.
- redirect_i  in  1  taken branch; sampled only on handshake.
- redirect_pc_i  in  ADDR_W  branch target.
- halted_o  out  1  HALT reached.
- ready_o  out  1  init window complete.

Behaviour:
- Reset (async, rst_i low): state WAIT_INIT.
  - Init counter = 0, pc = 0, start_pend = 0.
  - All outputs 0: mem_ren_o, mem_raddr_o, instr_valid_o, instr_opcode_o, instr_arg_o, instr_pc_o, halted_o, ready_o.
- WAIT_INIT:
  - Counts INIT_CYCLES clocks; mem_ren_o held 0.
  - A start_i seen here sets start_pend.
  - On the count reaching INIT_CYCLES-1, ready_o <= 1. Next state is FETCH with pc = 0 if start_pend (or start_i this cycle), otherwise IDLE.
- IDLE: start_i -> pc <= 0, state FETCH.
- FETCH:
  - mem_ren_o = 1, mem_raddr_o = pc; exactly one cycle.
  - Next state RESP.
- RESP:
  - mem_rdata_i is valid this cycle.
  - If mem_rdata_i == 0: state HALTED, halted_o <= 1, no instruction presented.
  - Otherwise register opcode/arg/instr_pc = pc, instr_valid_o <= 1, state VALID.
- VALID:
  - Outputs held stable while instr_ready_i = 0.
  - On handshake (valid & ready): instr_valid_o <= 0, state FETCH.
  - pc <= redirect_pc_i if redirect_i, else pc + 1, modulo 2**ADDR_W (pc = 15 wraps to 0).
- HALTED:
  - halted_o stays 1; no reads issue.
  - start_i -> halted_o <= 0, pc <= 0, state FETCH.
- Latency and throughput:
  - FETCH at cycle t, instr_valid_o high at t+2.
  - Minimum 3 cycles per instruction; at most one read outstanding.
- stop_i:
  - In any state except WAIT_INIT: next state IDLE, instr_valid_o <= 0, halted_o <= 0.
  - Priority over start_i and over the handshake (an instruction presented that cycle is discarded, pc unchanged).
  - In WAIT_INIT: clears start_pend.
- redirect_i without a handshake is ignored.
- The block never writes program memory; it relies on the memory's write-first read semantics for coherent self-modification.
- Reset mid-operation aborts immediately; any in-flight read is discarded.

Test Plan:
- Init window: release reset, pulse start_i at cycle 3.
  - -> mem_ren_o stays 0 for cycles 0-15.
  - -> ready_o = 1 at cycle 15.
  - -> first read, addr 0, at cycle 16.
- Decode/handshake: memory model word 0 = 8'h45, ready held high.
  - -> instr_valid_o 2 cycles after the read, opcode 3'b010, arg 5'd5, instr_pc_o 0.
  - -> next read addr 1 one cycle after the handshake.
- Backpressure: hold instr_ready_i low 5 cycles.
  - -> valid/opcode/arg/pc remain constant.
  - -> no mem_ren_o until accepted.
- Redirect and wrap:
  - Handshake at pc 10 with redirect_i = 1, redirect_pc_i = 4 -> next read addr 4.
  - Sequential fetch from pc 15 -> next read addr 0.
- HALT: word 3 = 8'h00.
  - -> halted_o = 1 two cycles after the addr-3 read; instr_valid_o never asserts for it.
  - -> start_i -> halted_o = 0, read addr 0.
- stop_i during VALID with instr_ready_i = 1.
  - -> no pc advance, instr_valid_o = 0 next cycle, state IDLE.
  - -> async reset during RESP -> all outputs 0 immediately.
